bcd_7_seg: RTL and testbench
============================

# bcd_7_seg

Registered BCD-to-seven-segment decoder for one display digit. It takes a 4-bit BCD code and drives seven segment lines with a one-cycle registered latency. It also provides lamp-test, blanking and an invalid-code flag. It sits between digit-selection/counter logic and the display pad drivers.

## Interface
- `ACTIVE_LOW`, default 0: 0 = segment on is driven 1 (common cathode); 1 = all `seg` bits inverted at the output register (common anode).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `bcd` input 4: digit code; 0–9 valid, 10–15 invalid.
- `lamp_test` input 1: force all segments on.
- `blank` input 1: force all segments off.
- `seg` output 7: segment drive. `seg[6]`=a, `seg[5]`=b, `seg[4]`=c, `seg[3]`=d, `seg[2]`=e, `seg[1]`=f, `seg[0]`=g.
- `invalid` output 1: registered flag, 1 when the sampled `bcd` is greater than 9.

## Operation
- Segment patterns below are given for `ACTIVE_LOW`=0.
- Digit patterns:
  - 0→7E, 1→30, 2→6D, 3→79, 4→33
  - 5→5B, 6→5F, 7→70, 8→7F, 9→7B
- Codes 10–15 give the blank pattern 00 (unless `BCD_7_SEG_HEX_EN` is defined; see Configuration).
- Priority each cycle: `rst` > `lamp_test` > `blank` > decode.
  - `lamp_test`=1 → pattern 7F.
  - `blank`=1 → pattern 00.
- `invalid` is set for `bcd` > 9 regardless of `lamp_test`/`blank`. It is cleared only by `rst` or by sampling a valid code.
- With `ACTIVE_LOW`=1, the stored `seg` value is the bitwise inverse of the pattern. `invalid` is never inverted.
- Decode is purely combinational into the output register. There is no other state.

## Timing
- Latency: `bcd`, `lamp_test` and `blank` sampled at rising edge N appear on `seg`/`invalid` after edge N (one cycle). They then hold until the next edge.
- Reset value of `seg`: blank. That is 00 when `ACTIVE_LOW`=0, 7F when `ACTIVE_LOW`=1.
- Reset value of `invalid`: 0.
- Reset asserted mid-stream overrides all inputs on that edge. The first decoded value appears one edge after `rst` deasserts.
- Outputs change only on rising edges; there are no combinational input-to-output paths.
- Back-to-back code changes every cycle are each reflected in the following cycle; no codes are dropped.

## Configuration
- `BCD_7_SEG_HEX_EN` defined: codes 10–15 decode to hexadecimal glyphs.
  - A→77, b→1F, C→4E, d→3D, E→4F, F→47.
  - `invalid` still asserts for these codes.
- `BCD_7_SEG_HEX_EN` undefined: codes 10–15 decode to blank (00 before polarity inversion).
- Priority, latency and reset behaviour are identical in both builds.

## Test plan
- Reset: hold `rst`=1 with `bcd`=8 for 2 cycles → `seg`=00, `invalid`=0. Release → next edge `seg`=7F.
- Sweep: apply `bcd`=0..9, one code per cycle → each table value appears one cycle later (0→7E … 9→7B) with `invalid`=0.
- Invalid code: `bcd`=15 → next cycle `invalid`=1 and `seg`=00. Repeat in the `BCD_7_SEG_HEX_EN` build → `seg`=47, `invalid`=1.
- Overrides with `bcd`=3:
  - `lamp_test`=1 and `blank`=1 together → `seg`=7F.
  - `blank`=1 alone → 00.
  - Both low → 79.
- Polarity: `ACTIVE_LOW`=1, `bcd`=1 → `seg`=4F. Reset → 7F.
- Mid-stream reset: with `bcd`=9 running, assert `rst` for one edge → `seg`=00. The next edge gives 7B.

Source files
------------

// File: rtl/bcd_7_seg.sv
// Registered BCD-to-seven-segment decoder with lamp-test, blanking and invalid-code flag.
// One-cycle latency, no flow control; define BCD_7_SEG_HEX_EN to show A-F glyphs for codes 10-15.
module bcd_7_seg #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    input  logic       lamp_test,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       invalid
);

    localparam logic [6:0] PAT_BLANK = 7'h00;
    localparam logic [6:0] PAT_ALL   = 7'h7F;
    localparam logic [6:0] POL_MASK  = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [6:0] digit_pat;
    logic [6:0] pattern;
    logic       code_bad;

    // Segment order is {a,b,c,d,e,f,g}, msb first.
    always_comb begin
        digit_pat = PAT_BLANK;
        case (bcd)
            4'd0:    digit_pat = 7'h7E;
            4'd1:    digit_pat = 7'h30;
            4'd2:    digit_pat = 7'h6D;
            4'd3:    digit_pat = 7'h79;
            4'd4:    digit_pat = 7'h33;
            4'd5:    digit_pat = 7'h5B;
            4'd6:    digit_pat = 7'h5F;
            4'd7:    digit_pat = 7'h70;
            4'd8:    digit_pat = 7'h7F;
            4'd9:    digit_pat = 7'h7B;
`ifdef BCD_7_SEG_HEX_EN
            4'd10:   digit_pat = 7'h77;
            4'd11:   digit_pat = 7'h1F;
            4'd12:   digit_pat = 7'h4E;
            4'd13:   digit_pat = 7'h3D;
            4'd14:   digit_pat = 7'h4F;
            4'd15:   digit_pat = 7'h47;
`endif
            default: digit_pat = PAT_BLANK;
        endcase
    end

    always_comb begin
        code_bad = (bcd > 4'd9);
        if (lamp_test) begin
            pattern = PAT_ALL;
        end else if (blank) begin
            pattern = PAT_BLANK;
        end else begin
            pattern = digit_pat;
        end
    end

    // Polarity is applied at the register so reset lands on the panel's "off" level.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg     <= PAT_BLANK ^ POL_MASK;
            invalid <= 1'b0;
        end else begin
            seg     <= pattern ^ POL_MASK;
            invalid <= code_bad;
        end
    end

endmodule

// File: tb/tb_bcd_7_seg.sv
// Directed bench for bcd_7_seg: one instance per polarity sharing stimulus.
module tb_bcd_7_seg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd;
    logic       lamp_test;
    logic       blank;
    logic [6:0] seg;
    logic       invalid;
    logic [6:0] seg_n;
    logic       invalid_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_7_seg #(.ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .bcd(bcd), .lamp_test(lamp_test), .blank(blank),
        .seg(seg), .invalid(invalid)
    );

    bcd_7_seg #(.ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst(rst), .bcd(bcd), .lamp_test(lamp_test), .blank(blank),
        .seg(seg_n), .invalid(invalid_n)
    );

    function automatic logic [6:0] exp_pat(input logic [3:0] code);
        case (code)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h5F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h7B;
`ifdef BCD_7_SEG_HEX_EN
            4'd10: return 7'h77;
            4'd11: return 7'h1F;
            4'd12: return 7'h4E;
            4'd13: return 7'h3D;
            4'd14: return 7'h4F;
            4'd15: return 7'h47;
`endif
            default: return 7'h00;
        endcase
    endfunction

    // Advance past one rising edge; outputs are then stable until the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bcd = 4'd8; lamp_test = 1'b0; blank = 1'b0;
        step();
        step();
        checks++;
        if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg got %h want 00", seg); end
        checks++;
        if (invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got %b want 0", invalid); end
        checks++;
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg_n got %h want 7f", seg_n); end
        rst = 1'b0;
        step();
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL release_seg got %h want 7f", seg); end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 10; i++) begin
            bcd = 4'(i);
            step();
            checks++;
            if (seg !== exp_pat(4'(i)) || invalid !== 1'b0) begin
                errors++;
                $display("FAIL sweep_%0d got seg=%h inv=%b want seg=%h inv=0", i, seg, invalid, exp_pat(4'(i)));
            end
        end
    endtask

    task automatic test_invalid();
        for (int i = 10; i < 16; i++) begin
            bcd = 4'(i);
            step();
            checks++;
            if (seg !== exp_pat(4'(i)) || invalid !== 1'b1) begin
                errors++;
                $display("FAIL invalid_%0d got seg=%h inv=%b want seg=%h inv=1", i, seg, invalid, exp_pat(4'(i)));
            end
        end
        // Flag ignores overrides and clears on the next valid code.
        bcd = 4'd15; lamp_test = 1'b1;
        step();
        checks++;
        if (seg !== 7'h7F || invalid !== 1'b1) begin
            errors++; $display("FAIL invalid_lamp got seg=%h inv=%b want seg=7f inv=1", seg, invalid);
        end
        bcd = 4'd12; lamp_test = 1'b0; blank = 1'b1;
        step();
        checks++;
        if (seg !== 7'h00 || invalid !== 1'b1) begin
            errors++; $display("FAIL invalid_blank got seg=%h inv=%b want seg=00 inv=1", seg, invalid);
        end
        bcd = 4'd2; blank = 1'b0;
        step();
        checks++;
        if (seg !== 7'h6D || invalid !== 1'b0) begin
            errors++; $display("FAIL invalid_clear got seg=%h inv=%b want seg=6d inv=0", seg, invalid);
        end
    endtask

    task automatic test_override();
        bcd = 4'd3; lamp_test = 1'b1; blank = 1'b1;
        step();
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL ovr_both got %h want 7f", seg); end
        lamp_test = 1'b0;
        step();
        checks++;
        if (seg !== 7'h00) begin errors++; $display("FAIL ovr_blank got %h want 00", seg); end
        checks++;
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL ovr_blank_n got %h want 7f", seg_n); end
        blank = 1'b0;
        step();
        checks++;
        if (seg !== 7'h79) begin errors++; $display("FAIL ovr_none got %h want 79", seg); end
    endtask

    task automatic test_polarity();
        bcd = 4'd1;
        step();
        checks++;
        if (seg_n !== 7'h4F) begin errors++; $display("FAIL pol_one got %h want 4f", seg_n); end
        bcd = 4'd14;
        step();
        checks++;
        if (invalid_n !== 1'b1) begin errors++; $display("FAIL pol_invalid got %b want 1", invalid_n); end
        rst = 1'b1;
        step();
        checks++;
        if (seg_n !== 7'h7F || invalid_n !== 1'b0) begin
            errors++; $display("FAIL pol_reset got seg=%h inv=%b want seg=7f inv=0", seg_n, invalid_n);
        end
        rst = 1'b0;
    endtask

    task automatic test_midstream_reset();
        bcd = 4'd9;
        step();
        checks++;
        if (seg !== 7'h7B) begin errors++; $display("FAIL mid_pre got %h want 7b", seg); end
        rst = 1'b1; lamp_test = 1'b1;
        step();
        checks++;
        if (seg !== 7'h00) begin errors++; $display("FAIL mid_rst got %h want 00", seg); end
        rst = 1'b0; lamp_test = 1'b0;
        step();
        checks++;
        if (seg !== 7'h7B) begin errors++; $display("FAIL mid_post got %h want 7b", seg); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [6] = '{4'd9, 4'd0, 4'd15, 4'd5, 4'd7, 4'd4};
        logic [6:0] want_seg [6] = '{7'h7B, 7'h7E, 7'h00, 7'h5B, 7'h70, 7'h33};
        logic       want_inv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef BCD_7_SEG_HEX_EN
        want_seg[2] = 7'h47;
`endif
        for (int i = 0; i < 6; i++) begin
            bcd = seq[i];
            step();
            checks++;
            if (seg !== want_seg[i] || invalid !== want_inv[i] || seg_n !== ~want_seg[i]) begin
                errors++;
                $display("FAIL b2b_%0d got seg=%h inv=%b seg_n=%h want seg=%h inv=%b", i, seg, invalid, seg_n,
                         want_seg[i], want_inv[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_invalid();
        test_override();
        test_polarity();
        test_midstream_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
